// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame on open-drain ps2c/ps2d, timeout abort.
// Build option: define PS2_TX_ACK_EN to check the device acknowledge bit after the stop bit.
module ps2_tx #(
  parameter int RTS_CYCLES     = 10000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err,
  output logic [2:0] dbg_state,
  output logic       dbg_ps2d
);

  localparam int RW = $clog2(RTS_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RTS   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_ACK   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                state;
  logic [8:0]            b;
  logic [3:0]            n;
  logic [RW-1:0]         rts_cnt;
  logic [TW-1:0]         to_cnt;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  filt_val;
  logic                  fall_edge;
  logic                  timeout;

  // Glitch filter: the filtered clock only changes after FILTER_LEN identical samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_reg <= '1;
      filt_val <= 1'b1;
    end else begin
      filt_reg <= {ps2c_in, filt_reg[FILTER_LEN-1:1]};
      if (&filt_reg)
        filt_val <= 1'b1;
      else if (~|filt_reg)
        filt_val <= 1'b0;
    end
  end

  assign fall_edge = filt_val & ~|filt_reg;
  assign timeout   = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign dbg_state = state;

  // Data line as seen at the most recent filtered ps2c falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      dbg_ps2d <= 1'b1;
    else if (fall_edge)
      dbg_ps2d <= ps2d_in;
  end

  // Handshake: a byte is taken only on a cycle with wr_ps2=1 and tx_idle=1; wr_ps2 at
  // any other time is dropped (not queued), and tx_idle falls on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      b            <= '0;
      n            <= '0;
      rts_cnt      <= '0;
      to_cnt       <= '0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      tx_err       <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          if (wr_ps2) begin
            b       <= {~^din, din};
            rts_cnt <= RW'(RTS_CYCLES - 1);
            ps2c_oe <= 1'b1;
            tx_idle <= 1'b0;
            state   <= S_RTS;
          end else begin
            tx_idle <= 1'b1;
          end
        end

        S_RTS: begin
          if (rts_cnt == '0) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            to_cnt  <= '0;
            state   <= S_START;
          end else begin
            rts_cnt <= rts_cnt - RW'(1);
          end
        end

        S_START: begin
          if (fall_edge) begin
            ps2d_oe <= ~b[0];
            n       <= 4'd8;
            to_cnt  <= '0;
            state   <= S_DATA;
          end else if (timeout) begin
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            tx_done_tick <= 1'b1;
            tx_err       <= 1'b1;
            state        <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        S_DATA: begin
          if (fall_edge) begin
            b      <= {1'b0, b[8:1]};
            to_cnt <= '0;
            if (n == 4'd0) begin
              ps2d_oe <= 1'b0;
              state   <= S_STOP;
            end else begin
              ps2d_oe <= ~b[1];
              n       <= n - 4'd1;
            end
          end else if (timeout) begin
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            tx_done_tick <= 1'b1;
            tx_err       <= 1'b1;
            state        <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        S_STOP: begin
          if (fall_edge) begin
            to_cnt <= '0;
`ifdef PS2_TX_ACK_EN
            state  <= S_ACK;
`else
            tx_done_tick <= 1'b1;
            state        <= S_DONE;
`endif
          end else if (timeout) begin
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            tx_done_tick <= 1'b1;
            tx_err       <= 1'b1;
            state        <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        S_ACK: begin
          // The device acknowledges by holding ps2d low; a high line means no ack.
          if (fall_edge) begin
            tx_done_tick <= 1'b1;
            tx_err       <= ps2d_in;
            state        <= S_DONE;
          end else if (timeout) begin
            tx_done_tick <= 1'b1;
            tx_err       <= 1'b1;
            state        <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        S_DONE: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          tx_idle <= 1'b1;
          state   <= S_IDLE;
        end

        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          tx_idle <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the DUT and compares the sampled
// bits, done/error pulses and line releases against values computed from the frame rules.
module tb_ps2_tx;

  localparam int RTS  = 20;
  localparam int FL   = 4;
  localparam int TO   = 500;
  localparam int HALF = 100;
`ifdef PS2_TX_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       wr_ps2 = 1'b0;
  logic [7:0] din    = 8'h00;
  logic       dev_c  = 1'b1;
  logic       dev_d  = 1'b1;
  logic       ps2c_line, ps2d_line;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err;
  logic [2:0] dbg_state;
  logic       dbg_ps2d;

  // open-drain wired-AND of host and device on each line
  assign ps2c_line = ~ps2c_oe & dev_c;
  assign ps2d_line = ~ps2d_oe & dev_d;

  ps2_tx #(.RTS_CYCLES(RTS), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2c_in(ps2c_line), .ps2d_in(ps2d_line),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick), .tx_err(tx_err),
    .dbg_state(dbg_state), .dbg_ps2d(dbg_ps2d)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int both_oe     = 0;
  int err_alone   = 0;
  logic last_err  = 1'b0;
  logic done_oe   = 1'b0;
  logic [0:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: done pulses, error value and line state at the pulse, illegal line combinations
  always @(negedge clk) begin
    if (tx_done_tick) begin
      done_cnt = done_cnt + 1;
      last_err = tx_err;
      done_cyc = cyc;
      done_oe  = ps2c_oe | ps2d_oe;
    end
    if (tx_err && !tx_done_tick) err_alone = err_alone + 1;
    if (ps2c_oe && ps2d_oe) both_oe = both_oe + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: start 0, data LSB first, odd parity, stop 1
  task automatic push_frame(input logic [7:0] d, input int nbits);
    logic [0:0] bits[11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = 1'((int'(d) / (1 << i)) % 2);
    bits[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    bits[10] = 1'b1;
    for (int i = 0; i < nbits; i++) exp_q.push_back(bits[i]);
  endtask

  // driver: one-cycle write request, din scrambled afterwards
  task automatic send_req(input logic [7:0] d);
    @(negedge clk);
    wr_ps2 = 1'b1;
    din    = d;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_rts(output int len);
    int t;
    t   = 0;
    len = 0;
    while (!ps2c_oe && t < 50) begin @(negedge clk); t++; end
    while (ps2c_oe && len < 200) begin len++; @(negedge clk); end
  endtask

  // device model: n_edges clock pulses, samples ps2d at each falling edge, optional ack,
  // optional one-cycle wr_ps2 pulse (din=0) in the low phase of edge poke_edge
  task automatic dev_frame(input int n_edges, input bit do_ack, input int poke_edge,
                           output logic [10:0] cap, output int last_fall);
    cap = '1;
    last_fall = 0;
    for (int k = 1; k <= n_edges; k++) begin
      repeat (HALF) @(negedge clk);
      dev_c = 1'b0;
      last_fall = cyc;
      if (k <= 11) cap[k-1] = ps2d_line;
      for (int i = 0; i < HALF; i++) begin
        @(negedge clk);
        if (k == poke_edge && i == 10) begin
          wr_ps2 = 1'b1;
          din    = 8'h00;
        end else if (k == poke_edge && i == 11) begin
          wr_ps2 = 1'b0;
        end
      end
      dev_c = 1'b1;
      if (k == 11 && do_ack) dev_d = 1'b0;
    end
    repeat (20) @(negedge clk);
    dev_d = 1'b1;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int t;
    t = 0;
    while (done_cnt == d0 && t < budget) begin @(negedge clk); t++; end
  endtask

  task automatic check_bits(input string tag, input logic [10:0] cap, input int nbits);
    for (int j = 0; j < nbits; j++)
      chk($sformatf("%s_bit%0d", tag, j), 32'(cap[j]), 32'(exp_q.pop_front()));
  endtask

  task automatic full_frame(input string tag, input logic [7:0] d, input bit do_ack,
                            input int poke);
    int d0, len, lf, rts_again;
    logic [10:0] cap;
    d0 = done_cnt;
    send_req(d);
    chk({tag, "_busy"}, 32'(tx_idle), 0);
    wait_rts(len);
    chk({tag, "_rts_len"}, len, RTS);
    chk({tag, "_start_drive"}, 32'(ps2d_oe), 1);
    dev_frame(12, do_ack, poke, cap, lf);
    wait_done(d0, 1000);
    repeat (50) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt, d0 + 1);
    chk({tag, "_err"}, 32'(last_err), (!do_ack && ACK_EN) ? 1 : 0);
    push_frame(d, 11);
    check_bits(tag, cap, 11);
    chk({tag, "_idle"}, 32'(tx_idle), 1);
    rts_again = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ps2c_oe) rts_again++;
    end
    chk({tag, "_no_restart"}, rts_again, 0);
  endtask

  initial begin : stimulus
    int d0, len, lf, rts_seen;
    logic [10:0] cap;
    logic [7:0] r;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_c_oe", 32'(ps2c_oe), 0);
    chk("rst_d_oe", 32'(ps2d_oe), 0);
    chk("rst_idle", 32'(tx_idle), 1);
    chk("rst_done", 32'(tx_done_tick), 0);
    chk("rst_err", 32'(tx_err), 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // reset asserted during request-to-send
    d0 = done_cnt;
    send_req(8'hA5);
    repeat (8) @(negedge clk);
    chk("midrts_c_oe", 32'(ps2c_oe), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrts_rst_c_oe", 32'(ps2c_oe), 0);
    chk("midrts_rst_d_oe", 32'(ps2d_oe), 0);
    chk("midrts_rst_idle", 32'(tx_idle), 1);
    @(negedge clk);
    reset = 1'b1;
    rts_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ps2c_oe) rts_seen++;
    end
    chk("midrts_no_done", done_cnt, d0);
    chk("midrts_no_resume", rts_seen, 0);

    // directed command bytes
    full_frame("ed", 8'hED, 1'b1, 0);
    full_frame("f4", 8'hF4, 1'b1, 0);

    // write request during DATA must be ignored
    full_frame("poke", 8'h3C, 1'b1, 5);

    // random bytes
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      full_frame($sformatf("rnd%0d", i), r, 1'b1, 0);
    end

    // device stops clocking after the 4th data bit
    r  = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    send_req(r);
    wait_rts(len);
    chk("to_rts_len", len, RTS);
    dev_frame(5, 1'b0, 0, cap, lf);
    wait_done(d0, 2000);
    repeat (5) @(negedge clk);
    chk("to_done_once", done_cnt, d0 + 1);
    chk("to_err", 32'(last_err), 1);
    chk("to_lines_released", 32'(done_oe), 0);
    chk("to_latency_ok", 32'((done_cyc - lf) >= TO && (done_cyc - lf) <= TO + 20), 1);
    push_frame(r, 5);
    check_bits("to", cap, 5);
    chk("to_idle", 32'(tx_idle), 1);

    // device omits the ack bit
    full_frame("noack", 8'hED, 1'b0, 0);

    chk("oe_exclusive", both_oe, 0);
    chk("err_only_with_done", err_alone, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
